// File: rtl/sha3_round_sequencer_pkg.sv
// Shared types and constants for the SHA-3 round sequencer.
// Holds the FSM state type and round-counter sizing.
package sha3_ctrl_pkg;

    localparam int ROUND_W       = 5;
    localparam int KECCAK_ROUNDS = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/sha3_round_sequencer_if.sv
// Handshake bundle between the round sequencer and its environment.
// The slave side is the sequencer; the master side drives requests.
interface sha3_round_sequencer_if
    import sha3_ctrl_pkg::*;
();
    logic               start_valid;
    logic               start_ready;
    logic               chain_sample;
    logic               chain_sel;
    logic [ROUND_W-1:0] round_idx;
    logic               last_round;
    logic               chain_good;
    logic               result_valid;
    logic               result_ready;
    logic               busy;
    logic               err_timeout;

    modport master (
        output start_valid,
        output chain_good,
        output result_ready,
        input  start_ready,
        input  chain_sample,
        input  chain_sel,
        input  round_idx,
        input  last_round,
        input  result_valid,
        input  busy,
        input  err_timeout
    );

    modport slave (
        input  start_valid,
        input  chain_good,
        input  result_ready,
        output start_ready,
        output chain_sample,
        output chain_sel,
        output round_idx,
        output last_round,
        output result_valid,
        output busy,
        output err_timeout
    );

endinterface

// File: rtl/sha3_round_sequencer_watchdog.sv
// 8-bit watchdog counting WAIT cycles since the last chain sample.
// expired flags the cycle in which the count reaches TIMEOUT-1.
module sha3_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 2);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/sha3_round_sequencer.sv
// Sequencer for one Keccak-f[1600] permutation through the
// theta/rho-pi/chi/iota chain; control only, no lane data.
module sha3_round_sequencer
    import sha3_ctrl_pkg::*;
#(
    parameter int ROUNDS  = KECCAK_ROUNDS,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    sha3_round_sequencer_if.slave seq
);
    localparam logic [ROUND_W-1:0] LAST = ROUND_W'(ROUNDS - 1);

    seq_state_t         state_q;
    logic [ROUND_W-1:0] round_q;
    logic               sel_q;
    logic               err_q;
    logic               sample_q;
    logic               rvalid_q;
    logic               ready_q;
    logic               busy_q;
    logic               wd_exp;

    sha3_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == S_ISSUE),
        .enable (state_q == S_WAIT),
        .expired(wd_exp)
    );

    // Outputs are flopped alongside the state so none depend on inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
            sample_q <= 1'b0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (seq.start_valid) begin
                        state_q  <= S_ISSUE;
                        round_q  <= '0;
                        sel_q    <= 1'b0;
                        err_q    <= 1'b0;
                        sample_q <= 1'b1;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A good arriving with watchdog expiry takes priority.
                    if (seq.chain_good) begin
                        if (round_q == LAST) begin
                            state_q  <= S_HOLD;
                            rvalid_q <= 1'b1;
                        end else begin
                            state_q  <= S_ISSUE;
                            round_q  <= round_q + 1'b1;
                            sel_q    <= 1'b1;
                            sample_q <= 1'b1;
                        end
                    end else if (wd_exp) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (seq.result_ready) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign seq.start_ready  = ready_q;
    assign seq.chain_sample = sample_q;
    assign seq.chain_sel    = sel_q;
    assign seq.round_idx    = round_q;
    assign seq.last_round   = (round_q == LAST);
    assign seq.result_valid = rvalid_q;
    assign seq.busy         = busy_q;
    assign seq.err_timeout  = err_q;

endmodule

// File: doc/sha3_round_sequencer.md
# sha3_round_sequencer

Control block that runs one Keccak-f[1600] permutation through the round-stage chain (theta → rho/pi → chi → iota). It accepts a permutation request, fires the chain's sample strobe once per round, and steers the chain input mux between the external state (round 0) and the loop-back state (rounds 1..ROUNDS-1). It supplies the round index for the iota constant, presents completion via a valid/ready handshake, and flags a chain that never reports `good`. It is control-only: no lane data passes through it.

## Interface
- `ROUNDS`, 24: rounds per permutation; legal range 1..32.
- `TIMEOUT`, 16: maximum WAIT cycles allowed for `chain_good` after a sample; legal range 2..255.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start_valid` in 1: permutation request; the external state is already valid at the chain input.
- `start_ready` out 1: the block accepts a request.
- `chain_sample` out 1: single-cycle sample strobe into the first chain stage.
- `chain_sel` out 1: 0 selects the external state, 1 selects the loop-back state.
- `round_idx` out 5: current round, 0..ROUNDS-1.
- `last_round` out 1: high when `round_idx == ROUNDS-1`.
- `chain_good` in 1: the chain output is valid for the last sample.
- `result_valid` out 1: permutation complete; the chain output holds the result.
- `result_ready` in 1: consumer takes the result.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states are IDLE, ISSUE, WAIT, HOLD and ERR. All outputs decode from registered state and counters. The block has no combinational input-to-output path.
- **IDLE:** `start_ready=1`. When `start_valid` is high, the block goes to ISSUE, clears `round_idx` to 0, clears `chain_sel` to 0, and clears `err_timeout`.
- **ISSUE:** lasts exactly one cycle with `chain_sample=1`, then goes to WAIT. The watchdog counter clears to 0.
- **WAIT:**
  - If `chain_good` is high and `round_idx == ROUNDS-1`, go to HOLD.
  - If `chain_good` is high otherwise, increment `round_idx`, set `chain_sel=1`, and go to ISSUE.
  - If `chain_good` is low, increment the watchdog. When it reaches TIMEOUT-1 and `chain_good` is still low, go to ERR.
  - `chain_good` arriving in the same cycle as watchdog expiry wins: the block follows the good path.
- **HOLD:** `result_valid=1`. `round_idx` and `chain_sel` hold their values. `chain_sample` stays 0 for as long as `result_ready` is low. `result_ready` high goes to IDLE.
- **ERR:** one cycle, then IDLE. `err_timeout` sets on entry to ERR and stays set until the next accepted start. No `result_valid` is produced.
- `chain_good` is ignored in IDLE, ISSUE, HOLD and ERR, including stale pulses from an aborted run.
- `start_valid` is ignored outside IDLE. There is no queuing.
- `round_idx` never exceeds ROUNDS-1 and never wraps mid-permutation.
- With ROUNDS=1, the first good in WAIT goes directly to HOLD.

## Timing
- Reset values (asynchronous, while `rst`=0): state IDLE, `start_ready=1`, `busy=0`, `chain_sample=0`, `chain_sel=0`, `round_idx=0`, `last_round=0` (1 only when ROUNDS=1), `result_valid=0`, `err_timeout=0`, watchdog 0.
- Reset mid-permutation aborts immediately. After release the block is in IDLE and any late `chain_good` is ignored.
- Let a request be accepted in cycle 0 and let L ≥ 1 be the chain latency in cycles from sample to good.
  - The first `chain_sample` is in cycle 1.
  - Round k samples in cycle 1+k(L+1).
  - `result_valid` rises in cycle ROUNDS·(L+1)+1. For ROUNDS=24 and L=1 that is cycle 49.
- The earliest next acceptance is the cycle after the `result_valid`/`result_ready` handshake.
- For `chain_sel`:
  - It changes to 1 in the same cycle as the round-1 `chain_sample`.
  - The chain mux must be stable by the edge that samples.
- A watchdog expiry enters ERR exactly TIMEOUT cycles after the ISSUE cycle if `chain_good` stays low.

## Structure
- Package `sha3_ctrl_pkg` holds:
  - the state enum `seq_state_t`;
  - `ROUND_W=5`;
  - `KECCAK_ROUNDS=24`, the default for ROUNDS.
- Sub-module `sha3_watchdog` is an 8-bit counter. It has inputs clear/enable, parameter TIMEOUT, and output `expired`. It is reset asynchronously by `rst`.
- The top level holds the FSM, the round counter and the output decode.

## Test plan
- **Nominal run:** ROUNDS=24, chain model L=1, `result_ready` tied high, start in cycle 0.
  - `chain_sample` pulses in cycles 1,3,…,47 (24 pulses).
  - `chain_sel` is 0 only at the cycle-1 sample.
  - `result_valid` is high in cycle 49 for 1 cycle, and `round_idx` reads 23 there.
- **Backpressure:** L=3, `result_ready` held low for 10 cycles after `result_valid`.
  - `result_valid` rises in cycle 97 and holds for 10 cycles.
  - No `chain_sample` appears and `start_ready=0` throughout.
  - IDLE is reached the cycle after `result_ready` rises.
- **Watchdog:** TIMEOUT=16, the chain never asserts good.
  - ERR is entered in cycle 17, then IDLE in cycle 18.
  - `err_timeout` stays high until the next accepted start, which clears it the next cycle.
- **Good at expiry:** `chain_good` arrives exactly in the expiry cycle of round 5.
  - No ERR occurs and `round_idx` advances to 6.
- **Async reset at round 10:** `rst` low for 3 cycles mid-WAIT.
  - All outputs take their reset values immediately.
  - A stale `chain_good` after release is ignored, and the block stays in IDLE.
- **Ignored inputs:** `start_valid` pulsed during WAIT and `chain_good` pulsed in IDLE.
  - Neither changes state, `round_idx`, or the count of `chain_sample` pulses.
